// File: rtl/accel_apb_mailbox.sv
// ---------------------------------------------------------------------------
// accel_apb_mailbox
//   A two-way mailbox between the CPU and an accelerator core. It sits as an
//   APB slave in one of the accel bus1 peripheral slots.
//   - TX FIFO: APB writes to DATA are offered to the core as a valid/ready
//     stream.
//   - RX FIFO: words from the core stream are popped by APB reads of DATA.
//   - A level interrupt is raised while RX occupancy is at or above a
//     programmable threshold.
//
// Ports
//   i_clk, i_nrst   clock and asynchronous active-low reset
//   i_mapinfo       base/end address of this slot (echoed into o_cfg)
//   o_cfg           static plug-and-play descriptor
//   i_apbi/o_apbo   APB request and registered APB response
//   o_tx_*/i_tx_*   TX stream towards the core
//   i_rx_*/o_rx_*   RX stream from the core
//   o_irq           registered RX level interrupt
//   o_dbg_state     current APB FSM state (IDLE=0, RESP=1)
//
// Handshake rule (both streams): a word moves on a rising clock edge where
// valid and ready are both high. Valid never depends on ready.
// ---------------------------------------------------------------------------
package accel_apb_mailbox_pkg;

  localparam logic [15:0] VENDOR_OPTIMITECH        = 16'h00F1;
  localparam logic [15:0] OPTIMITECH_ACCEL_MAILBOX = 16'h0F20;
  localparam logic [7:0]  PNP_CFG_DEV_DESCR_BYTES  = 8'h10;
  localparam logic [1:0]  PNP_CFG_TYPE_SLAVE       = 2'b10;

  typedef struct packed {
    logic [63:0] addr_start;
    logic [63:0] addr_end;
  } mapinfo_type;

  typedef struct packed {
    logic [7:0]  descrsize;
    logic [1:0]  descrtype;
    logic [63:0] addr_start;
    logic [63:0] addr_end;
    logic [15:0] vid;
    logic [15:0] did;
  } dev_config_type;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

endpackage

module accel_apb_mailbox
  import accel_apb_mailbox_pkg::*;
#(
  parameter int log2_depth = 3
) (
  input  logic           i_clk,
  input  logic           i_nrst,
  input  mapinfo_type    i_mapinfo,
  output dev_config_type o_cfg,
  input  apb_in_type     i_apbi,
  output apb_out_type    o_apbo,
  output logic           o_tx_valid,
  output logic [31:0]    o_tx_data,
  input  logic           i_tx_ready,
  input  logic           i_rx_valid,
  input  logic [31:0]    i_rx_data,
  output logic           o_rx_ready,
  output logic           o_irq,
  output logic [0:0]     o_dbg_state
);

  localparam int depth = 1 << log2_depth;
  // Count value of a full FIFO: only the top bit set.
  localparam logic [log2_depth:0] full_cnt = {1'b1, {log2_depth{1'b0}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  // Register word indices (paddr[11:2]).
  localparam logic [9:0] IDX_DATA = 10'd0;
  localparam logic [9:0] IDX_STAT = 10'd1;
  localparam logic [9:0] IDX_CTRL = 10'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [0:0]            state;
  logic                  pready_q;
  logic [31:0]           prdata_q;
  logic                  pslverr_q;

  logic [31:0]           tx_mem [depth];
  logic [31:0]           rx_mem [depth];
  logic [log2_depth-1:0] tx_wr;
  logic [log2_depth-1:0] tx_rd;
  logic [log2_depth-1:0] rx_wr;
  logic [log2_depth-1:0] rx_rd;
  logic [log2_depth:0]   tx_cnt;
  logic [log2_depth:0]   rx_cnt;

  logic                  ovf;
  logic                  udf;
  logic                  irq_en;
  logic [7:0]            rx_thresh;
  logic                  irq_q;
  // Holds the RX ready low while reset is asserted and releases it one
  // clock after reset is removed.
  logic                  rst_done;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic [9:0]  reg_idx;
  logic        setup;
  logic        is_data;
  logic        is_stat;
  logic        is_ctrl;
  logic        apb_push;
  logic        apb_pop;
  logic        ctrl_wr;
  logic        flush;

  logic        tx_empty;
  logic        tx_full;
  logic        rx_empty;
  logic        rx_full;
  logic        tx_push;
  logic        tx_pop;
  logic        rx_push;
  logic        rx_pop;

  logic [7:0]  tx_cnt8;
  logic [7:0]  rx_cnt8;
  logic [31:0] stat_word;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        wr_err;

  assign reg_idx  = i_apbi.paddr[11:2];
  // The access is performed in the setup cycle; the response is registered
  // so that pready is high exactly during the access cycle.
  assign setup    = (state == ST_IDLE) & i_apbi.pselx & ~i_apbi.penable;
  assign is_data  = (reg_idx == IDX_DATA);
  assign is_stat  = (reg_idx == IDX_STAT);
  assign is_ctrl  = (reg_idx == IDX_CTRL);

  assign apb_push = setup & i_apbi.pwrite & is_data;
  assign apb_pop  = setup & ~i_apbi.pwrite & is_data;
  assign ctrl_wr  = setup & i_apbi.pwrite & is_ctrl;
  assign flush    = ctrl_wr & i_apbi.pstrb[3] & i_apbi.pwdata[31];

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == full_cnt);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == full_cnt);

  // A push into a full FIFO is dropped even if the same cycle pops it.
  assign tx_push  = apb_push & ~tx_full;
  assign tx_pop   = ~tx_empty & i_tx_ready;
  assign rx_push  = i_rx_valid & o_rx_ready;
  assign rx_pop   = apb_pop & ~rx_empty;

  assign tx_cnt8  = 8'(tx_cnt);
  assign rx_cnt8  = 8'(rx_cnt);

  assign stat_word = {10'h000, udf, ovf, rx_cnt8, tx_cnt8,
                      rx_full, rx_empty, tx_full, tx_empty};

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (is_data) begin
      if (rx_empty) begin
        rd_data = '1;
        rd_err  = 1'b1;
      end else begin
        rd_data = rx_mem[rx_rd];
      end
    end else if (is_stat) begin
      rd_data = stat_word;
    end else if (is_ctrl) begin
      rd_data = {16'h0000, rx_thresh, 7'h00, irq_en};
    end
  end

  assign wr_err = is_data & tx_full;

  // -------------------------------------------------------------------------
  // APB response FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state     <= ST_IDLE;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            state     <= ST_RESP;
            pready_q  <= 1'b1;
            prdata_q  <= i_apbi.pwrite ? 32'h0 : rd_data;
            pslverr_q <= i_apbi.pwrite ? wr_err : rd_err;
          end
        end
        default: begin
          state     <= ST_IDLE;
          pready_q  <= 1'b0;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Control and status flags
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      irq_en    <= 1'b0;
      rx_thresh <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
      irq_q     <= 1'b0;
      rst_done  <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (ctrl_wr && i_apbi.pstrb[0]) begin
        irq_en <= i_apbi.pwdata[0];
      end
      if (ctrl_wr && i_apbi.pstrb[1]) begin
        rx_thresh <= i_apbi.pwdata[15:8];
      end
      if (flush) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (apb_push && tx_full) begin
          ovf <= 1'b1;
        end
        if (apb_pop && rx_empty) begin
          udf <= 1'b1;
        end
      end
      // Uses the current registered count, so the interrupt follows a
      // count change by one clock.
      irq_q <= irq_en & (rx_thresh != 8'h00) & (rx_cnt8 >= rx_thresh);
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and counts; a flush discards any coincident transfer.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else if (flush) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_wr <= tx_wr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd <= tx_rd + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase

      if (rx_push) begin
        rx_wr <= rx_wr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd <= rx_rd + 1'b1;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Storage is not reset; only words between the pointers are ever visible.
  always_ff @(posedge i_clk) begin
    if (tx_push) begin
      tx_mem[tx_wr] <= i_apbi.pwdata;
    end
    if (rx_push) begin
      rx_mem[rx_wr] <= i_rx_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_apbo.pready  = pready_q;
  assign o_apbo.prdata  = prdata_q;
  assign o_apbo.pslverr = pslverr_q;

  assign o_tx_valid  = ~tx_empty;
  assign o_tx_data   = tx_empty ? 32'h0 : tx_mem[tx_rd];
  assign o_rx_ready  = rst_done & ~rx_full;
  assign o_irq       = irq_q;
  assign o_dbg_state = state;

  assign o_cfg.descrsize  = PNP_CFG_DEV_DESCR_BYTES;
  assign o_cfg.descrtype  = PNP_CFG_TYPE_SLAVE;
  assign o_cfg.addr_start = i_mapinfo.addr_start;
  assign o_cfg.addr_end   = i_mapinfo.addr_end;
  assign o_cfg.vid        = VENDOR_OPTIMITECH;
  assign o_cfg.did        = OPTIMITECH_ACCEL_MAILBOX;

  // Address bits outside the register window, protection and byte lane 2
  // have no effect on this block.
  logic unused_inputs;
  assign unused_inputs = ^{i_apbi.paddr[31:12], i_apbi.paddr[1:0],
                           i_apbi.pprot, i_apbi.pstrb[2]};

endmodule

// File: tb/tb_accel_apb_mailbox.sv
// Testbench for accel_apb_mailbox: directed scenarios plus a randomized run
// against a queue-based model of the mailbox.
module tb_accel_apb_mailbox;
  import accel_apb_mailbox_pkg::*;

  localparam int DEPTH = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst;

  mapinfo_type    mapinfo;
  dev_config_type cfg;
  apb_in_type     apbi;
  apb_out_type    apbo;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;
  logic        irq;
  logic [0:0]  dbg_state;

  accel_apb_mailbox #(.log2_depth(3)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_mapinfo(mapinfo), .o_cfg(cfg),
    .i_apbi(apbi), .o_apbo(apbo),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
    .o_irq(irq), .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        m_ovf, m_udf, m_irq_en;
  logic [7:0]  m_thresh;

  function automatic void model_reset();
    tx_q.delete(); rx_q.delete();
    m_ovf = 0; m_udf = 0; m_irq_en = 0; m_thresh = 0;
  endfunction

  function automatic logic [31:0] exp_stat();
    logic [31:0] s;
    s = '0;
    s[0]     = (tx_q.size() == 0);
    s[1]     = (tx_q.size() == DEPTH);
    s[2]     = (rx_q.size() == 0);
    s[3]     = (rx_q.size() == DEPTH);
    s[11:4]  = 8'(tx_q.size());
    s[19:12] = 8'(rx_q.size());
    s[20]    = m_ovf;
    s[21]    = m_udf;
    return s;
  endfunction

  function automatic logic exp_irq();
    return m_irq_en && (m_thresh != 0) && (rx_q.size() >= int'(m_thresh));
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic apb_xfer(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err);
    @(negedge clk);
    apbi.paddr = addr; apbi.pwrite = we; apbi.pwdata = wdata; apbi.pstrb = strb;
    apbi.pselx = 1; apbi.penable = 0;
    @(posedge clk); #1;
    apbi.penable = 1;
    @(negedge clk);
    rdata = apbo.prdata; err = apbo.pslverr;
    checks++;
    if (apbo.pready !== 1'b1) begin
      errors++; $display("FAIL pready_access: got %b expected 1", apbo.pready);
    end
    @(posedge clk); #1;
    apbi.pselx = 0; apbi.penable = 0;
    @(negedge clk);
    checks++;
    if ({apbo.pready, apbo.pslverr, apbo.prdata} !== '0) begin
      errors++; $display("FAIL resp_idle: got %b/%b/%h expected 0/0/0",
                         apbo.pready, apbo.pslverr, apbo.prdata);
    end
  endtask

  task automatic op_write_data(input logic [31:0] d);
    logic [31:0] r; logic e, exp_e;
    exp_e = (tx_q.size() == DEPTH);
    if (exp_e) m_ovf = 1; else tx_q.push_back(d);
    apb_xfer(1, 32'h0, d, 4'hF, r, e);
    checks++;
    if (e !== exp_e) begin
      errors++; $display("FAIL write_data_err: got %b expected %b", e, exp_e);
    end
  endtask

  task automatic op_read_data();
    logic [31:0] r, exp_r; logic e, exp_e;
    exp_e = (rx_q.size() == 0);
    if (exp_e) begin exp_r = 32'hFFFF_FFFF; m_udf = 1; end
    else exp_r = rx_q.pop_front();
    apb_xfer(0, 32'h0, 32'h0, 4'h0, r, e);
    checks++;
    if (r !== exp_r || e !== exp_e) begin
      errors++; $display("FAIL read_data: got %h/%b expected %h/%b", r, e, exp_r, exp_e);
    end
  endtask

  task automatic op_read_stat();
    logic [31:0] r, exp_r; logic e;
    exp_r = exp_stat();
    apb_xfer(0, 32'h4, 32'h0, 4'h0, r, e);
    checks++;
    if (r !== exp_r || e !== 1'b0) begin
      errors++; $display("FAIL read_stat: got %h/%b expected %h/0", r, e, exp_r);
    end
  endtask

  task automatic op_write_ctrl(input logic [31:0] d, input logic [3:0] strb);
    logic [31:0] r; logic e;
    if (strb[0]) m_irq_en = d[0];
    if (strb[1]) m_thresh = d[15:8];
    if (strb[3] && d[31]) begin
      tx_q.delete(); rx_q.delete(); m_ovf = 0; m_udf = 0;
    end
    apb_xfer(1, 32'h8, d, strb, r, e);
    checks++;
    if (e !== 1'b0) begin
      errors++; $display("FAIL write_ctrl_err: got %b expected 0", e);
    end
  endtask

  task automatic op_read_ctrl();
    logic [31:0] r, exp_r; logic e;
    exp_r = {16'h0, m_thresh, 7'h0, m_irq_en};
    apb_xfer(0, 32'h8, 32'h0, 4'h0, r, e);
    checks++;
    if (r !== exp_r) begin
      errors++; $display("FAIL read_ctrl: got %h expected %h", r, exp_r);
    end
  endtask

  task automatic rx_push_word(input logic [31:0] d);
    logic exp_rdy;
    @(negedge clk);
    rx_valid = 1; rx_data = d;
    exp_rdy = (rx_q.size() < DEPTH);
    checks++;
    if (rx_ready !== exp_rdy) begin
      errors++; $display("FAIL rx_ready: got %b expected %b", rx_ready, exp_rdy);
    end
    if (exp_rdy) rx_q.push_back(d);
    @(posedge clk); #1;
    rx_valid = 0;
  endtask

  task automatic tx_drain();
    int guard;
    guard = 0;
    while (tx_q.size() != 0 && guard < 64) begin
      @(negedge clk);
      guard++;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== tx_q[0]) begin
        errors++; $display("FAIL tx_stream: got %b/%h expected 1/%h", tx_valid, tx_data, tx_q[0]);
      end
      tx_ready = 1;
      void'(tx_q.pop_front());
    end
    @(posedge clk); #1;
    tx_ready = 0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++; $display("FAIL tx_drained: got valid %b expected 0", tx_valid);
    end
  endtask

  task automatic check_irq();
    logic exp_i;
    @(posedge clk); @(negedge clk);
    exp_i = exp_irq();
    checks++;
    if (irq !== exp_i) begin
      errors++; $display("FAIL irq_level: got %b expected %b", irq, exp_i);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    nrst = 0;
    apbi = '0; tx_ready = 0; rx_valid = 0; rx_data = '0;
    mapinfo.addr_start = 64'h0000_0000_0800_3000;
    mapinfo.addr_end   = 64'h0000_0000_0800_4000;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({apbo.pready, apbo.pslverr, apbo.prdata, tx_valid, tx_data, rx_ready, irq} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b/%b/%h/%b/%h/%b/%b expected all 0",
        apbo.pready, apbo.pslverr, apbo.prdata, tx_valid, tx_data, rx_ready, irq);
    end
    nrst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
      errors++; $display("FAIL after_reset: got rx_ready %b tx_valid %b expected 1 0", rx_ready, tx_valid);
    end
    checks++;
    if (cfg.vid !== 16'h00F1 || cfg.addr_start !== 64'h0800_3000) begin
      errors++; $display("FAIL cfg: got %h/%h expected 00f1/08003000", cfg.vid, cfg.addr_start);
    end
    op_read_stat();
    op_read_ctrl();
  endtask

  task automatic test_tx_stream();
    op_write_data(32'h11);
    op_write_data(32'h22);
    op_read_stat();
    tx_drain();
    op_read_stat();
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < 9; i++) op_write_data(32'h100 + i);
    op_read_stat();
    op_write_ctrl(32'h8000_0000, 4'b1000);
    op_read_stat();
  endtask

  task automatic test_rx_underflow();
    rx_push_word(32'hA5A5_A5A5);
    op_read_data();
    op_read_data();
    op_read_stat();
    op_write_ctrl(32'h8000_0000, 4'b1000);
    op_read_stat();
  endtask

  task automatic test_irq();
    op_write_ctrl(32'h0000_0301, 4'b0011);
    op_read_ctrl();
    rx_push_word(32'h1); check_irq();
    rx_push_word(32'h2); check_irq();
    rx_push_word(32'h3);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_latency: got %b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got %b expected 1", irq);
    end
    op_read_data();
    check_irq();
    op_write_ctrl(32'h8000_0000, 4'b1111);
    check_irq();
  endtask

  task automatic test_rx_full_pop();
    logic [31:0] exp_r;
    for (int i = 0; i < DEPTH; i++) rx_push_word(32'hC000 + i);
    op_read_stat();
    @(negedge clk);
    rx_valid = 1; rx_data = 32'hDEAD_BEEF;
    apbi.paddr = 0; apbi.pwrite = 0; apbi.pstrb = 0; apbi.pselx = 1; apbi.penable = 0;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++; $display("FAIL full_rx_ready: got %b expected 0", rx_ready);
    end
    exp_r = rx_q.pop_front();
    @(posedge clk); #1;
    rx_valid = 0; apbi.penable = 1;
    @(negedge clk);
    checks++;
    if (apbo.prdata !== exp_r || apbo.pslverr !== 1'b0 || apbo.pready !== 1'b1) begin
      errors++; $display("FAIL full_pop: got %h/%b/%b expected %h/0/1",
                         apbo.prdata, apbo.pslverr, apbo.pready, exp_r);
    end
    @(posedge clk); #1;
    apbi.pselx = 0; apbi.penable = 0;
    op_read_stat();
    while (rx_q.size() != 0) op_read_data();
    op_read_data();
    op_write_ctrl(32'h8000_0000, 4'b1000);
  endtask

  task automatic test_unmapped();
    logic [31:0] r; logic e;
    apb_xfer(0, 32'h10, 32'h0, 4'h0, r, e);
    checks++;
    if (r !== 32'h0 || e !== 1'b0) begin
      errors++; $display("FAIL unmapped_read: got %h/%b expected 0/0", r, e);
    end
    apb_xfer(1, 32'h3C, 32'hFFFF_FFFF, 4'hF, r, e);
    op_read_stat();
    op_read_ctrl();
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0, 1: op_write_data($urandom);
        2, 3: op_read_data();
        4:    op_read_stat();
        5:    rx_push_word($urandom);
        6: begin
          if ($urandom_range(0, 2) == 0) tx_drain();
          else begin
            d = $urandom;
            d[31] = ($urandom_range(0, 7) == 0);
            d[15:8] = 8'($urandom_range(0, 9));
            op_write_ctrl(d, 4'($urandom));
          end
        end
        default: op_read_ctrl();
      endcase
      check_irq();
    end
  endtask

  task automatic test_reset_mid();
    op_write_data(32'h55);
    op_write_data(32'h66);
    rx_push_word(32'h77);
    @(negedge clk);
    apbi.paddr = 0; apbi.pwrite = 1; apbi.pwdata = 32'h88; apbi.pstrb = 4'hF;
    apbi.pselx = 1; apbi.penable = 0;
    @(posedge clk); #1;
    nrst = 0;
    #1;
    checks++;
    if ({apbo.pready, tx_valid, tx_data, rx_ready, irq} !== '0) begin
      errors++; $display("FAIL reset_mid: got %b/%b/%h/%b/%b expected all 0",
                         apbo.pready, tx_valid, tx_data, rx_ready, irq);
    end
    apbi = '0;
    model_reset();
    @(negedge clk);
    nrst = 1;
    repeat (2) @(negedge clk);
    op_read_stat();
    op_read_ctrl();
    op_write_data(32'h99);
    tx_drain();
    rx_push_word(32'hABCD);
    op_read_data();
    op_read_stat();
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_tx_overflow();
    test_rx_underflow();
    test_irq();
    test_rx_full_pop();
    test_unmapped();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
